// File: rtl/quad_decoder_pkg.sv
// rtl/quad_decoder_pkg.sv - shared types, constants and the Gray-step decoder
// for the quadrature decoder.
package quad_decoder_pkg;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_PRIME,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ILLEGAL
  } step_t;

  localparam int SYNC_DEPTH = 2;

  // Position of an AB pair along the forward cycle 00 -> 10 -> 11 -> 01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    logic [1:0] pos;
    case (ab)
      2'b00:   pos = 2'd0;
      2'b10:   pos = 2'd1;
      2'b11:   pos = 2'd2;
      default: pos = 2'd3;
    endcase
    return pos;
  endfunction

  function automatic step_t decode_step(input logic [1:0] prev_ab, input logic [1:0] ab);
    logic [1:0] delta;
    step_t      code;
    delta = gray_pos(ab) - gray_pos(prev_ab);
    case (delta)
      2'd0:    code = STEP_NONE;
      2'd1:    code = STEP_UP;
      2'd3:    code = STEP_DOWN;
      default: code = STEP_ILLEGAL;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/quad_decoder_if.sv
// rtl/quad_decoder_if.sv - phase inputs, controls and count/status outputs
// of the quadrature decoder.
interface quad_decoder_if #(
  parameter int WIDTH = 8
);
  logic             a_in;
  logic             b_in;
  logic             en;
  logic             clr;
  logic [WIDTH-1:0] count;
  logic             dir;
  logic             step;
  logic             err;

  modport master (
    output a_in, b_in, en, clr,
    input  count, dir, step, err
  );

  modport slave (
    input  a_in, b_in, en, clr,
    output count, dir, step, err
  );
endinterface

// File: rtl/quad_sync_filt.sv
// rtl/quad_sync_filt.sv - per-phase 2-flop synchronizer with an optional
// stable-sample filter (FILT_CYCLES = 0 bypasses the filter).
module quad_sync_filt
  import quad_decoder_pkg::*;
#(
  parameter int FILT_CYCLES = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic d_out
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic [SYNC_DEPTH-1:0] sync_d;

  always_comb sync_d = {sync_q[SYNC_DEPTH-2:0], d_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  if (FILT_CYCLES > 0) begin : g_filt
    logic       filt_q, filt_d;
    logic [3:0] run_q, run_d;

    // run_q counts consecutive samples that disagree with the filtered level.
    always_comb begin
      filt_d = filt_q;
      run_d  = '0;
      if (sync_q[SYNC_DEPTH-1] != filt_q) begin
        if (run_q == 4'(FILT_CYCLES - 1)) filt_d = sync_q[SYNC_DEPTH-1];
        else                              run_d  = run_q + 4'd1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        filt_q <= 1'b0;
        run_q  <= '0;
      end else begin
        filt_q <= filt_d;
        run_q  <= run_d;
      end
    end

    assign d_out = filt_q;
  end else begin : g_nofilt
    assign d_out = sync_q[SYNC_DEPTH-1];
  end

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature A/B decoder with position count, direction,
// step pulse and sticky error; QUAD_DECODER_FILTER_EN adds the input filter.
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int WRAP     = 1,
  parameter int FILT_LEN = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  quad_decoder_if.slave  bus
);

`ifdef QUAD_DECODER_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif
  localparam int         FILT_CYCLES = FILT_ON ? FILT_LEN : 0;
  localparam int         INIT_WAIT   = SYNC_DEPTH + FILT_CYCLES;
  localparam logic [4:0] INIT_LAST   = 5'(INIT_WAIT - 1);

  logic       a_s, b_s;
  logic [1:0] ab;

  quad_sync_filt #(.FILT_CYCLES(FILT_CYCLES)) u_sync_a (
    .clk(clk), .rst_n(rst_n), .d_in(bus.a_in), .d_out(a_s)
  );
  quad_sync_filt #(.FILT_CYCLES(FILT_CYCLES)) u_sync_b (
    .clk(clk), .rst_n(rst_n), .d_in(bus.b_in), .d_out(b_s)
  );

  assign ab = {a_s, b_s};

  state_t           state_q, state_d;
  logic [4:0]       init_cnt_q, init_cnt_d;
  logic [1:0]       prev_ab_q, prev_ab_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             err_q, err_d;

  step_t code;
  logic  is_up;
  logic  at_rail;

  assign code    = decode_step(prev_ab_q, ab);
  assign is_up   = (code == STEP_UP);
  assign at_rail = is_up ? (count_q == {WIDTH{1'b1}}) : (count_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      prev_ab_q  <= '0;
      count_q    <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_ab_q  <= prev_ab_d;
      count_q    <= count_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_ab_d  = prev_ab_q;
    count_d    = count_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    err_d      = err_q;

    if (bus.clr) begin
      count_d = '0;
      err_d   = 1'b0;
    end

    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == INIT_LAST) state_d    = ST_PRIME;
        else                         init_cnt_d = init_cnt_q + 5'd1;
      end
      ST_PRIME: begin
        prev_ab_d = ab;
        state_d   = ST_RUN;
      end
      ST_RUN: begin
        prev_ab_d = ab;
        // An illegal jump still flags even when clr lands on the same cycle.
        if (code == STEP_ILLEGAL) begin
          err_d = 1'b1;
        end else if (bus.en && code != STEP_NONE) begin
          dir_d = is_up;
          if (!bus.clr && !(WRAP == 0 && at_rail)) begin
            count_d = is_up ? count_q + 1'b1 : count_q - 1'b1;
            step_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign bus.count = count_q;
  assign bus.dir   = dir_q;
  assign bus.step  = step_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - directed bench driving a wrapping and a saturating
// decoder from the same A/B stimulus; QUAD_DECODER_FILTER_EN adds a filter test.
module tb_quad_decoder;

`ifdef QUAD_DECODER_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif
  localparam int SETTLE = 4;

  logic clk, rst_n, a, b, en, clr;
  int   n_vec, n_err, sw, ss;

  quad_decoder_if #(.WIDTH(8)) if_w ();
  quad_decoder_if #(.WIDTH(8)) if_s ();

  assign if_w.a_in = a;
  assign if_w.b_in = b;
  assign if_w.en   = en;
  assign if_w.clr  = clr;
  assign if_s.a_in = a;
  assign if_s.b_in = b;
  assign if_s.en   = en;
  assign if_s.clr  = clr;

  quad_decoder #(.WIDTH(8), .WRAP(1), .FILT_LEN(3)) u_wrap (
    .clk(clk), .rst_n(rst_n), .bus(if_w)
  );
  quad_decoder #(.WIDTH(8), .WRAP(0), .FILT_LEN(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(if_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic hold(input int n);
    repeat (n) begin
      @(negedge clk);
      if (if_w.step) sw++;
      if (if_s.step) ss++;
    end
  endtask

  task automatic set_ab(input logic [1:0] ab);
    a = ab[1];
    b = ab[0];
  endtask

  task automatic move(input logic [1:0] ab);
    set_ab(ab);
    hold(5);
  endtask

  task automatic test_reset;
    rst_n = 1'b1; a = 1'b0; b = 1'b0; en = 1'b1; clr = 1'b0;
    #1 rst_n = 1'b0;
    hold(2);
    n_vec++; if (if_w.count !== 8'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", if_w.count); end
    n_vec++; if (if_w.dir !== 1'b0) begin n_err++; $display("FAIL rst_dir got %b want 0", if_w.dir); end
    n_vec++; if (if_w.step !== 1'b0) begin n_err++; $display("FAIL rst_step got %b want 0", if_w.step); end
    n_vec++; if (if_w.err !== 1'b0) begin n_err++; $display("FAIL rst_err got %b want 0", if_w.err); end
    n_vec++; if (if_s.count !== 8'd0) begin n_err++; $display("FAIL rst_sat_count got %0d want 0", if_s.count); end
    rst_n = 1'b1;
    sw = 0; ss = 0;
    hold(10);
    n_vec++; if (sw !== 0) begin n_err++; $display("FAIL rst_release_steps got %0d want 0", sw); end
  endtask

  task automatic test_forward;
    sw = 0; ss = 0;
    set_ab(2'b10);
    hold(LAT - 1);
    n_vec++; if (if_w.step !== 1'b0) begin n_err++; $display("FAIL fwd_lat_early got %b want 0", if_w.step); end
    hold(1);
    n_vec++; if (if_w.step !== 1'b1) begin n_err++; $display("FAIL fwd_lat_step got %b want 1", if_w.step); end
    n_vec++; if (if_w.count !== 8'd1) begin n_err++; $display("FAIL fwd_lat_count got %0d want 1", if_w.count); end
    hold(1);
    n_vec++; if (if_w.step !== 1'b0) begin n_err++; $display("FAIL fwd_pulse_width got %b want 0", if_w.step); end
    hold(2);
    move(2'b11); move(2'b01); move(2'b00);
    hold(SETTLE);
    n_vec++; if (if_w.count !== 8'd4) begin n_err++; $display("FAIL fwd_count got %0d want 4", if_w.count); end
    n_vec++; if (sw !== 4) begin n_err++; $display("FAIL fwd_steps got %0d want 4", sw); end
    n_vec++; if (if_w.dir !== 1'b1) begin n_err++; $display("FAIL fwd_dir got %b want 1", if_w.dir); end
    n_vec++; if (if_w.err !== 1'b0) begin n_err++; $display("FAIL fwd_err got %b want 0", if_w.err); end
    n_vec++; if (if_s.count !== 8'd4) begin n_err++; $display("FAIL fwd_sat_count got %0d want 4", if_s.count); end
  endtask

  task automatic test_wrap;
    move(2'b01); move(2'b11);
    hold(SETTLE);
    n_vec++; if (if_w.count !== 8'd2) begin n_err++; $display("FAIL wrap_pre_count got %0d want 2", if_w.count); end
    sw = 0; ss = 0;
    move(2'b10); move(2'b00);
    hold(SETTLE);
    n_vec++; if (if_s.count !== 8'd0) begin n_err++; $display("FAIL sat_reach_zero got %0d want 0", if_s.count); end
    n_vec++; if (ss !== 2) begin n_err++; $display("FAIL sat_reach_steps got %0d want 2", ss); end
    ss = 0;
    move(2'b01); move(2'b11); move(2'b10);
    hold(SETTLE);
    n_vec++; if (if_w.count !== 8'd253) begin n_err++; $display("FAIL wrap_count got %0d want 253", if_w.count); end
    n_vec++; if (sw !== 5) begin n_err++; $display("FAIL wrap_steps got %0d want 5", sw); end
    n_vec++; if (if_w.dir !== 1'b0) begin n_err++; $display("FAIL wrap_dir got %b want 0", if_w.dir); end
    n_vec++; if (if_s.count !== 8'd0) begin n_err++; $display("FAIL sat_low_count got %0d want 0", if_s.count); end
    n_vec++; if (ss !== 0) begin n_err++; $display("FAIL sat_low_steps got %0d want 0", ss); end
    n_vec++; if (if_s.dir !== 1'b0) begin n_err++; $display("FAIL sat_low_dir got %b want 0", if_s.dir); end
  endtask

  task automatic test_saturate;
    sw = 0; ss = 0;
    move(2'b11);
    hold(SETTLE);
    n_vec++; if (if_s.count !== 8'd1) begin n_err++; $display("FAIL sat_up_count got %0d want 1", if_s.count); end
    n_vec++; if (ss !== 1) begin n_err++; $display("FAIL sat_up_steps got %0d want 1", ss); end
    n_vec++; if (if_s.dir !== 1'b1) begin n_err++; $display("FAIL sat_up_dir got %b want 1", if_s.dir); end
    n_vec++; if (if_w.count !== 8'd254) begin n_err++; $display("FAIL wrap_up1_count got %0d want 254", if_w.count); end
  endtask

  task automatic test_wrap_up;
    sw = 0; ss = 0;
    move(2'b01); move(2'b00);
    hold(SETTLE);
    n_vec++; if (if_w.count !== 8'd0) begin n_err++; $display("FAIL wrap_top_count got %0d want 0", if_w.count); end
    n_vec++; if (sw !== 2) begin n_err++; $display("FAIL wrap_top_steps got %0d want 2", sw); end
    n_vec++; if (if_s.count !== 8'd3) begin n_err++; $display("FAIL sat_mid_count got %0d want 3", if_s.count); end
  endtask

  task automatic test_illegal;
    sw = 0; ss = 0;
    set_ab(2'b11);
    hold(LAT - 1);
    n_vec++; if (if_w.err !== 1'b0) begin n_err++; $display("FAIL ill_err_early got %b want 0", if_w.err); end
    hold(1);
    n_vec++; if (if_w.err !== 1'b1) begin n_err++; $display("FAIL ill_err got %b want 1", if_w.err); end
    n_vec++; if (if_s.count !== 8'd3) begin n_err++; $display("FAIL ill_count got %0d want 3", if_s.count); end
    hold(3);
    n_vec++; if (if_s.err !== 1'b1) begin n_err++; $display("FAIL ill_sticky got %b want 1", if_s.err); end
    n_vec++; if (ss !== 0) begin n_err++; $display("FAIL ill_steps got %0d want 0", ss); end
    clr = 1'b1;
    hold(1);
    clr = 1'b0;
    n_vec++; if (if_w.err !== 1'b0) begin n_err++; $display("FAIL clr_err got %b want 0", if_w.err); end
    n_vec++; if (if_s.count !== 8'd0) begin n_err++; $display("FAIL clr_count got %0d want 0", if_s.count); end
    n_vec++; if (if_s.err !== 1'b0) begin n_err++; $display("FAIL clr_sat_err got %b want 0", if_s.err); end
  endtask

  task automatic test_enable;
    sw = 0; ss = 0;
    en = 1'b0;
    move(2'b01); move(2'b00); move(2'b10);
    hold(SETTLE);
    n_vec++; if (if_w.count !== 8'd0) begin n_err++; $display("FAIL en_off_count got %0d want 0", if_w.count); end
    n_vec++; if (sw !== 0) begin n_err++; $display("FAIL en_off_steps got %0d want 0", sw); end
    n_vec++; if (if_w.err !== 1'b0) begin n_err++; $display("FAIL en_off_err got %b want 0", if_w.err); end
    en = 1'b1;
    move(2'b11);
    hold(SETTLE);
    n_vec++; if (if_w.count !== 8'd1) begin n_err++; $display("FAIL en_on_count got %0d want 1", if_w.count); end
    n_vec++; if (sw !== 1) begin n_err++; $display("FAIL en_on_steps got %0d want 1", sw); end
  endtask

  task automatic test_reset_mid;
    set_ab(2'b01);
    hold(1);
    rst_n = 1'b0;
    #1;
    n_vec++; if (if_w.count !== 8'd0) begin n_err++; $display("FAIL mid_rst_count got %0d want 0", if_w.count); end
    n_vec++; if (if_w.dir !== 1'b0) begin n_err++; $display("FAIL mid_rst_dir got %b want 0", if_w.dir); end
    n_vec++; if (if_s.count !== 8'd0) begin n_err++; $display("FAIL mid_rst_sat_count got %0d want 0", if_s.count); end
    hold(2);
    rst_n = 1'b1;
    sw = 0; ss = 0;
    hold(12);
    n_vec++; if (sw !== 0) begin n_err++; $display("FAIL prime_steps got %0d want 0", sw); end
    n_vec++; if (if_w.count !== 8'd0) begin n_err++; $display("FAIL prime_count got %0d want 0", if_w.count); end
    move(2'b00);
    hold(SETTLE);
    n_vec++; if (if_w.count !== 8'd1) begin n_err++; $display("FAIL post_rst_count got %0d want 1", if_w.count); end
    n_vec++; if (if_w.dir !== 1'b1) begin n_err++; $display("FAIL post_rst_dir got %b want 1", if_w.dir); end
  endtask

`ifdef QUAD_DECODER_FILTER_EN
  task automatic test_filter;
    sw = 0;
    set_ab(2'b10);
    hold(2);
    set_ab(2'b00);
    hold(12);
    n_vec++; if (sw !== 0) begin n_err++; $display("FAIL filt_glitch_steps got %0d want 0", sw); end
    set_ab(2'b10);
    hold(LAT - 1);
    n_vec++; if (if_w.step !== 1'b0) begin n_err++; $display("FAIL filt_lat_early got %b want 0", if_w.step); end
    hold(1);
    n_vec++; if (if_w.step !== 1'b1) begin n_err++; $display("FAIL filt_lat_step got %b want 1", if_w.step); end
    hold(4);
    n_vec++; if (if_w.count !== 8'd2) begin n_err++; $display("FAIL filt_count got %0d want 2", if_w.count); end
  endtask
`endif

  initial begin
    n_vec = 0; n_err = 0; sw = 0; ss = 0;
    test_reset();
    test_forward();
    test_wrap();
    test_saturate();
    test_wrap_up();
    test_illegal();
    test_enable();
    test_reset_mid();
`ifdef QUAD_DECODER_FILTER_EN
    test_filter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
